fifo_rd_ctrl: RTL and testbench

Read-side controller for the async FIFO. It is the consumer of the dual-port memory written on wclk.
- Owns the read pointer, the synchronizer for the incoming write pointer, the empty/almost-empty flags and the fill level.
- Presents memory data to the consumer through a first-word-fall-through output register with a valid/ready handshake.
- Lives entirely in the read clock domain and exports a Gray-coded read pointer back to the write side.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/fifo_rd_ctrl_sync.sv | 26 ++
 rtl/fifo_rd_ctrl.sv | 84 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Constants and Gray-code helpers shared by the read side, write side and memory of the async FIFO.
// The helpers work on zero-extended 32-bit values, so any pointer width up to 32 bits can use them.
package fifo_pkg;

    localparam int DSIZE_DEF = 8;
    localparam int ASIZE_DEF = 4;
    localparam int GW        = 32;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // A zero-extended Gray value decodes to the same binary value as its narrow form.
    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the clock domain of rclk.
module sync_w2r #(
    parameter int W = 5
) (
    input  logic         rclk,
    input  logic         rrst_n,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] ptr_o
);

    logic [W-1:0] q1_q;
    logic [W-1:0] q2_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= ptr_i;
            q2_q <= q1_q;
        end
    end

    assign ptr_o = q2_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, write-pointer synchronizer,
// empty/almost-empty flags, fill level, and a first-word-fall-through output register.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [ASIZE:0]   wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             rempty,
    output logic             raempty,
    output logic [ASIZE:0]   rlevel
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0]    wq2;
    logic [PW-1:0]    rbin_q, rbin_d;
    logic [PW-1:0]    rptr_q, rgray_d;
    logic [PW-1:0]    rlevel_q, rlevel_d;
    logic             rempty_q;
    logic             rd_valid_q, rd_valid_d;
    logic [DSIZE-1:0] rd_data_q, rd_data_d;
    logic             load;

    sync_w2r #(.W(PW)) u_sync_w2r (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .ptr_i  (wptr),
        .ptr_o  (wq2)
    );

    // Empty and level look at the post-pop pointer, so a pop on this edge is already accounted for.
    always_comb begin
        load       = !rempty_q && (!rd_valid_q || rd_ready);
        rbin_d     = rbin_q + PW'(load);
        rgray_d    = PW'(bin2gray(GW'(rbin_d)));
        rlevel_d   = PW'(gray2bin(GW'(wq2))) - rbin_d;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        if (load) begin
            rd_data_d  = mem_rdata;
            rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rlevel_q   <= '0;
            rempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rgray_d;
            rlevel_q   <= rlevel_d;
            rempty_q   <= (rgray_d == wq2);
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rptr     = rptr_q;
    assign raddr    = rbin_q[ASIZE-1:0];
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rempty   = rempty_q;
    assign rlevel   = rlevel_q;
    assign raempty  = (rlevel_q <= PW'(AE_THRESH));

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: a write-side model fills a memory array and a Gray write pointer,
// expected words are queued at write time, and a negedge monitor checks every accepted word.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int AE = 2;
  localparam int DEPTH = 16;

  logic          rclk = 1'b0;
  logic          rrst_n = 1'b1;
  logic [AW:0]   wptr = '0;
  logic [AW:0]   rptr;
  logic [AW-1:0] raddr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rempty;
  logic          raempty;
  logic [AW:0]   rlevel;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            wr_cnt = 0;
  int            accepted = 0;
  bit            mon_en = 0;
  bit            saw_wrap = 0;

  fifo_rd_ctrl #(.DSIZE(DW), .ASIZE(AW), .AE_THRESH(AE)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .wptr      (wptr),
    .rptr      (rptr),
    .raddr     (raddr),
    .mem_rdata (mem_rdata),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rempty    (rempty),
    .raempty   (raempty),
    .rlevel    (rlevel)
  );

  assign mem_rdata = mem[raddr];

  // ---------------- clock ----------------
  always #5 rclk = ~rclk;

  // ---------------- reference helpers ----------------
  function automatic logic [AW:0] gray5(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW:0] ungray5(input logic [AW:0] g);
    logic [AW:0] b;
    logic        acc;
    acc = 1'b0;
    for (int i = AW; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Write side: store the word, queue it as expected output, advance the Gray pointer by one.
  task automatic push_word(input logic [DW-1:0] d);
    logic [31:0] wc;
    wc = 32'(wr_cnt);
    mem[wc[AW-1:0]] = d;
    exp_q.push_back(d);
    wr_cnt++;
    wc = 32'(wr_cnt);
    wptr = gray5(wc[AW:0]);
  endtask

  task automatic do_reset();
    @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    rd_ready = 1'b0;
    wptr = '0;
    wr_cnt = 0;
    accepted = 0;
    saw_wrap = 0;
    exp_q.delete();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    #1 rrst_n = 1'b1;
    @(posedge rclk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge rclk);
      #1;
      n++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge rclk);
    #1;
  endtask

  task automatic run_random(input int n_words);
    int pushed;
    int guard;
    pushed = 0;
    guard = 0;
    while (pushed < n_words && guard < 3000) begin
      @(posedge rclk);
      #1;
      guard++;
      rd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && (wr_cnt - accepted) < DEPTH) begin
        push_word(DW'($urandom_range(0, 255)));
        pushed++;
      end
    end
    chk("random_words_pushed", 32'(pushed), 32'(n_words));
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [DW-1:0] prev_data;
  logic [AW:0]   prev_rptr = '0;
  logic [AW-1:0] prev_raddr;
  bit            prev_hold = 0;

  always @(negedge rclk) begin
    logic [AW:0] rb;
    if (!mon_en || !rrst_n) begin
      prev_hold = 0;
      prev_rptr = '0;
    end else begin
      chk("raempty_vs_rlevel", 32'(raempty), 32'(rlevel <= AE));
      if (rptr != prev_rptr) begin
        chk("rptr_single_bit_step", 32'($countones(rptr ^ prev_rptr)), 32'd1);
        if (prev_rptr == 5'b10000 && rptr == 5'b00000) saw_wrap = 1;
      end
      rb = ungray5(rptr);
      chk("raddr_matches_rptr", 32'(raddr), 32'(rb[AW-1:0]));
      if (prev_hold) begin
        chk("hold_rd_data", 32'(rd_data), 32'(prev_data));
        chk("hold_rptr", 32'(rptr), 32'(prev_rptr));
        chk("hold_raddr", 32'(raddr), 32'(prev_raddr));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", rd_data, $time);
        end else begin
          chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        accepted++;
      end
      prev_hold  = rd_valid && !rd_ready;
      prev_data  = rd_data;
      prev_rptr  = rptr;
      prev_raddr = raddr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] s_data;
    logic [AW:0]   s_rptr;
    logic [AW-1:0] s_raddr;
    logic [AW:0]   s_lvl;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    // 1. reset asserted mid-cycle clears immediately
    #12 rrst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rempty", 32'(rempty), 32'd1);
    chk("rst_raempty", 32'(raempty), 32'd1);
    chk("rst_rptr", 32'(rptr), 32'd0);
    chk("rst_raddr", 32'(raddr), 32'd0);
    chk("rst_rlevel", 32'(rlevel), 32'd0);
    mon_en = 1;
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    #1 rrst_n = 1'b1;
    @(posedge rclk);
    #1;

    // 2. single word, latency of the synchronizer and load
    rd_ready = 1'b0;
    push_word(8'hA5);
    @(posedge rclk);
    @(posedge rclk);
    #1 chk("single_rempty_edge2", 32'(rempty), 32'd1);
    @(posedge rclk);
    #1;
    chk("single_rempty_edge3", 32'(rempty), 32'd0);
    chk("single_rlevel_edge3", 32'(rlevel), 32'd1);
    chk("single_valid_edge3", 32'(rd_valid), 32'd0);
    @(posedge rclk);
    #1;
    chk("single_valid_edge4", 32'(rd_valid), 32'd1);
    chk("single_data_edge4", 32'(rd_data), 32'hA5);
    chk("single_rptr_edge4", 32'(rptr), 32'd1);
    chk("single_raddr_edge4", 32'(raddr), 32'd1);
    chk("single_rempty_edge4", 32'(rempty), 32'd1);
    chk("single_rlevel_edge4", 32'(rlevel), 32'd0);
    rd_ready = 1'b1;
    @(posedge rclk);
    #1;
    chk("single_valid_after_accept", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;

    // 3. full burst of 16 words, no bubble
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'(i + 10);
      exp_q.push_back(DW'(i + 10));
    end
    wr_cnt = DEPTH;
    wptr = gray5(5'd16);
    @(posedge rclk);
    @(posedge rclk);
    #1 chk("burst_rempty_edge2", 32'(rempty), 32'd1);
    @(posedge rclk);
    #1;
    chk("burst_rempty_edge3", 32'(rempty), 32'd0);
    chk("burst_rlevel_full", 32'(rlevel), 32'd16);
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge rclk);
      #1;
      chk("burst_valid_no_bubble", 32'(rd_valid), 32'd1);
      chk("burst_rlevel", 32'(rlevel), 32'(15 - k));
      chk("burst_raddr", 32'(raddr), 32'((k + 1) % DEPTH));
    end
    @(posedge rclk);
    #1;
    chk("burst_end_valid", 32'(rd_valid), 32'd0);
    chk("burst_end_rptr", 32'(rptr), 32'b11000);
    chk("burst_end_rempty", 32'(rempty), 32'd1);
    chk("burst_end_rlevel", 32'(rlevel), 32'd0);
    chk("burst_all_consumed", 32'(exp_q.size()), 32'd0);

    // 4. backpressure in the middle of a stream
    do_reset();
    rd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      push_word(DW'($urandom_range(0, 255)));
      @(posedge rclk);
      #1;
    end
    repeat (2) @(posedge rclk);
    #1;
    rd_ready = 1'b0;
    chk("bp_valid_at_hold", 32'(rd_valid), 32'd1);
    s_data = rd_data;
    s_rptr = rptr;
    s_raddr = raddr;
    s_lvl = rlevel;
    for (int k = 0; k < 5; k++) begin
      @(posedge rclk);
      #1;
      chk("bp_data_stable", 32'(rd_data), 32'(s_data));
      chk("bp_rptr_stable", 32'(rptr), 32'(s_rptr));
      chk("bp_raddr_stable", 32'(raddr), 32'(s_raddr));
      chk("bp_rlevel_stable", 32'(rlevel), 32'(s_lvl));
    end
    drain();
    chk("bp_accepted_count", 32'(accepted), 32'd12);

    // 5. random traffic across the pointer wrap
    do_reset();
    run_random(40);
    drain();
    chk("wrap_seen_10000_to_00000", 32'(saw_wrap), 32'd1);
    chk("wrap_final_rptr", 32'(rptr), 32'(gray5(5'd8)));
    chk("wrap_final_rempty", 32'(rempty), 32'd1);
    chk("wrap_final_rlevel", 32'(rlevel), 32'd0);
    chk("wrap_accepted_count", 32'(accepted), 32'd40);

    // 6. reset while a word is held and the memory holds 7 more
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_word(DW'($urandom_range(0, 255)));
      @(posedge rclk);
      #1;
    end
    repeat (3) @(posedge rclk);
    #1;
    chk("midrst_pre_valid", 32'(rd_valid), 32'd1);
    chk("midrst_pre_rlevel", 32'(rlevel), 32'd7);
    @(negedge rclk);
    #2 rrst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    chk("midrst_rd_data", 32'(rd_data), 32'd0);
    chk("midrst_rempty", 32'(rempty), 32'd1);
    chk("midrst_raempty", 32'(raempty), 32'd1);
    chk("midrst_rptr", 32'(rptr), 32'd0);
    chk("midrst_raddr", 32'(raddr), 32'd0);
    chk("midrst_rlevel", 32'(rlevel), 32'd0);
    wptr = '0;
    wr_cnt = 0;
    accepted = 0;
    exp_q.delete();
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    #1 rrst_n = 1'b1;
    rd_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge rclk);
      #1;
      chk("post_rst_no_valid", 32'(rd_valid), 32'd0);
      chk("post_rst_rempty", 32'(rempty), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
